// File: rtl/bsg_cache_sbuf_drain.sv
// bsg_cache_sbuf_drain: drains store-buffer entries into data-memory writes, arbitrates reads, handles flush.
module bsg_cache_sbuf_drain #(
    parameter int ways_p                = 4,
    parameter int addr_width_p          = 28,
    parameter int data_width_p          = 32,
    parameter int sets_p                = 64,
    parameter int block_size_in_words_p = 8,
    parameter int max_stall_p           = 4,
    localparam int lg_ways_lp          = $clog2(ways_p),
    localparam int data_mask_width_lp  = data_width_p / 8,
    localparam int lg_dmw_lp           = $clog2(data_mask_width_lp),
    localparam int lg_sets_lp          = $clog2(sets_p),
    localparam int lg_bsiw_lp          = $clog2(block_size_in_words_p),
    localparam int row_width_lp        = lg_sets_lp + lg_bsiw_lp,
    localparam int entry_width_lp      = addr_width_p + data_width_p + data_mask_width_lp + lg_ways_lp,
    localparam int starve_width_lp     = $clog2(max_stall_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [entry_width_lp-1:0]              sbuf_entry_i,
    input  logic                                   sbuf_v_i,
    output logic                                   sbuf_yumi_o,
    input  logic                                   sbuf_empty_i,
    input  logic                                   read_req_i,
    input  logic [row_width_lp-1:0]                read_addr_i,
    output logic                                   stall_o,
    output logic                                   data_mem_v_o,
    output logic                                   data_mem_w_o,
    output logic [row_width_lp-1:0]                data_mem_addr_o,
    output logic [ways_p*data_width_p-1:0]         data_mem_data_o,
    output logic [ways_p*data_mask_width_lp-1:0]   data_mem_w_mask_o,
    input  logic                                   flush_v_i,
    output logic                                   flush_done_o
);
    localparam int row_hi_lp = lg_dmw_lp + lg_bsiw_lp + lg_sets_lp;

    typedef enum logic {idle_s, flush_s} state_e;

    state_e state_r, state_n;
    logic [starve_width_lp-1:0] starve_r, starve_n;

    logic [addr_width_p-1:0]       addr;
    logic [data_width_p-1:0]       data;
    logic [data_mask_width_lp-1:0] mask;
    logic [lg_ways_lp-1:0]         way;
    logic [row_width_lp-1:0]       write_row;
    logic force_drain, write_grant, read_grant, live, unused_addr;

    assign addr = sbuf_entry_i[entry_width_lp-1 -: addr_width_p];
    assign data = sbuf_entry_i[entry_width_lp-addr_width_p-1 -: data_width_p];
    assign mask = sbuf_entry_i[lg_ways_lp +: data_mask_width_lp];
    assign way  = sbuf_entry_i[lg_ways_lp-1:0];
    assign write_row = {addr[row_hi_lp-1:lg_dmw_lp+lg_bsiw_lp], addr[lg_dmw_lp+lg_bsiw_lp-1:lg_dmw_lp]};
    assign unused_addr = ^{addr[addr_width_p-1:row_hi_lp], addr[lg_dmw_lp-1:0]};

    // every externally visible request/grant is suppressed while reset is held
    assign live        = ~reset_i;
    assign force_drain = (state_r == flush_s) | (starve_r == starve_width_lp'(max_stall_p));
    assign write_grant = live & sbuf_v_i & (~read_req_i | force_drain);
    assign read_grant  = live & read_req_i & ~force_drain & ~write_grant;

    assign sbuf_yumi_o     = write_grant;
    assign stall_o         = live & force_drain;
    assign flush_done_o    = live & (state_r == flush_s) & sbuf_empty_i;
    assign data_mem_v_o    = write_grant | read_grant;
    assign data_mem_w_o    = write_grant;
    assign data_mem_addr_o = write_grant ? write_row : read_addr_i;
    assign data_mem_data_o = {ways_p{data}};

    always_comb begin
        data_mem_w_mask_o = '0;
        for (int i = 0; i < ways_p; i++)
            if (way == lg_ways_lp'(i)) data_mem_w_mask_o[i*data_mask_width_lp +: data_mask_width_lp] = mask;
    end

    always_comb begin
        state_n = state_r;
        if (state_r == idle_s && flush_v_i) state_n = flush_s;
        if (state_r == flush_s && sbuf_empty_i) state_n = idle_s;
        starve_n = (write_grant | ~sbuf_v_i) ? '0
                 : (read_req_i & ~force_drain) ? starve_r + 1'b1
                 : starve_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= idle_s;
            starve_r <= '0;
        end else begin
            state_r  <= state_n;
            starve_r <= starve_n;
        end
    end
endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// tb_bsg_cache_sbuf_drain: directed vectors, per-cycle model comparison plus literal spot checks.
module tb_bsg_cache_sbuf_drain;
    localparam int MAXS = 4;

    logic clk = 0, rst = 1, sbuf_v = 0, empty = 1, rd = 0, flush_v = 0;
    logic [8:0] raddr = '0;
    logic [27:0] e_addr = '0;
    logic [31:0] e_data = '0;
    logic [3:0] e_mask = '0;
    logic [1:0] e_way = '0;
    logic [65:0] entry;
    logic yumi, stall, mv, mw, done;
    logic [8:0] maddr;
    logic [127:0] mdata;
    logic [15:0] mmask;
    int n_checks = 0, n_fail = 0;
    int m_denied = 0;
    bit m_flush = 0;
    bit frc, wg, rg;

    assign entry = {e_addr, e_data, e_mask, e_way};

    bsg_cache_sbuf_drain dut (
        .clk_i(clk), .reset_i(rst), .sbuf_entry_i(entry), .sbuf_v_i(sbuf_v), .sbuf_yumi_o(yumi),
        .sbuf_empty_i(empty), .read_req_i(rd), .read_addr_i(raddr), .stall_o(stall),
        .data_mem_v_o(mv), .data_mem_w_o(mw), .data_mem_addr_o(maddr), .data_mem_data_o(mdata),
        .data_mem_w_mask_o(mmask), .flush_v_i(flush_v), .flush_done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] row_of(input logic [27:0] a);
        int set_idx, word_idx;
        set_idx  = (int'(a) / 32) % 64;
        word_idx = (int'(a) / 4) % 8;
        return 9'(set_idx * 8 + word_idx);
    endfunction

    // model state: flush in progress, and how many consecutive cycles the sbuf head has lost to reads
    always @(posedge clk) begin
        if (rst) begin
            m_flush  <= 0;
            m_denied <= 0;
        end else begin
            if (m_flush) begin
                if (empty) m_flush <= 0;
            end else if (flush_v) m_flush <= 1;
            if (sbuf_v && rd && !(m_flush || m_denied == MAXS)) m_denied <= m_denied + 1;
            else m_denied <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_rst_outputs", {yumi, mv, stall, done}, 4'b0);
        end else begin
            frc = m_flush || m_denied == MAXS;
            wg  = sbuf_v && (!rd || frc);
            rg  = rd && !frc && !wg;
            chk("m_yumi", yumi, wg);
            chk("m_stall", stall, frc);
            chk("m_v", mv, wg || rg);
            chk("m_w", mw, wg);
            chk("m_done", done, m_flush && empty);
            if (wg) begin
                chk("m_waddr", maddr, row_of(e_addr));
                chk("m_wdata", mdata, {4{e_data}});
                chk("m_wmask", mmask, 16'(e_mask) << (4 * e_way));
            end else if (rg) chk("m_raddr", maddr, raddr);
        end
    end

    initial begin
        e_addr = 28'h0000A64; e_data = 32'hDEADBEEF; e_mask = 4'b0011; e_way = 2'd2;
        sbuf_v = 1; rd = 1; empty = 0;
        @(negedge clk); chk("reset_outputs", {yumi, mv, stall, done}, 4'b0);
        tick();
        rst = 0; rd = 0;
        @(negedge clk);
        chk("basic_handshake", {yumi, mv, mw}, 3'b111);
        chk("basic_addr", maddr, 9'h099);
        chk("basic_mask", mmask, 16'h0300);
        chk("basic_data", mdata, {4{32'hDEADBEEF}});
        tick();
        rd = 1; raddr = 9'h055;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("starve_read", {stall, yumi, mv, mw}, 4'b0010);
            chk("starve_raddr", maddr, 9'h055);
            tick();
        end
        @(negedge clk); chk("forced_write", {stall, yumi, mv, mw}, 4'b1111); tick();
        @(negedge clk); chk("read_after_force", {stall, yumi, mv, mw}, 4'b0010); tick();
        sbuf_v = 0;
        @(negedge clk); chk("idle_read", {stall, yumi, mv, mw}, 4'b0010); tick();
        sbuf_v = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("pre_clear_read", {stall, yumi}, 2'b00); tick();
        end
        sbuf_v = 0;
        @(negedge clk); chk("clear_cycle", {stall, mv, mw}, 3'b010); tick();
        sbuf_v = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("post_clear_read", {stall, yumi, mv, mw}, 4'b0010); tick();
        end
        @(negedge clk); chk("post_clear_force", {stall, yumi, mv, mw}, 4'b1111); tick();
        sbuf_v = 0; tick();
        rd = 0; sbuf_v = 1;
        for (int w = 0; w < 4; w++) begin
            e_way = 2'(w); e_addr = 28'h1234560 + 28'(w * 36);
            e_mask = 4'(w + 5); e_data = $urandom;
            tick();
        end
        e_way = 2'd3; e_addr = 28'h00007FC; e_mask = 4'b1010;
        @(negedge clk);
        chk("edge_addr", maddr, 9'h1FF);
        chk("edge_mask", mmask, 16'hA000);
        tick();
        sbuf_v = 0; tick();
        sbuf_v = 1; rd = 1; empty = 0; flush_v = 1; raddr = 9'h0AA;
        @(negedge clk); chk("flush_req_cycle", {stall, yumi, mv, mw}, 4'b0010); tick();
        flush_v = 0;
        @(negedge clk); chk("flush_write0", {stall, yumi, mv, mw}, 4'b1111); tick();
        @(negedge clk); chk("flush_write1", {stall, yumi, mv, mw}, 4'b1111); tick();
        sbuf_v = 0; empty = 1;
        @(negedge clk);
        chk("flush_done", done, 1'b1);
        chk("flush_done_stall", {stall, yumi, mv, mw}, 4'b1000);
        tick();
        @(negedge clk);
        chk("flush_done_once", done, 1'b0);
        chk("flush_then_read", {stall, yumi, mv, mw}, 4'b0010);
        chk("flush_then_raddr", maddr, 9'h0AA);
        tick();
        rd = 0; flush_v = 1;
        @(negedge clk); chk("empty_flush_req", {done, mv}, 2'b00); tick();
        flush_v = 0;
        @(negedge clk); chk("empty_flush_done", {done, mv, stall}, 3'b101); tick();
        @(negedge clk); chk("empty_flush_after", {done, stall}, 2'b00); tick();
        flush_v = 1; empty = 0;
        @(negedge clk); chk("rflush_req", done, 1'b0); tick();
        flush_v = 0;
        @(negedge clk); chk("rflush_stall", {stall, done}, 2'b10); tick();
        rst = 1; empty = 1; rd = 1;
        @(negedge clk); chk("rflush_in_reset", {yumi, mv, stall, done}, 4'b0); tick();
        rst = 0;
        @(negedge clk);
        chk("rflush_no_done", done, 1'b0);
        chk("rflush_read", {stall, mv, mw}, 3'b010);
        tick();
        @(negedge clk); chk("rflush_no_done2", done, 1'b0); tick();
        rd = 0; tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
